// File: rtl/prime_pkg.sv
// Shared types and defaults for the prime collector: FSM state encoding,
// default widths/depth, and the ceiling for the non-prime drop counter.
package prime_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 4;
    localparam int DEPTH_DEF  = 8;
    localparam int DROP_MAX   = 15;
endpackage

// File: rtl/prime_fifo.sv
// Synchronous FIFO with registered full/empty flags; a push into a full FIFO
// or a pop from an empty one is ignored.
module prime_fifo
    import prime_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              do_push, do_pop;

    // Flags are registered, so a pop never frees space for a push in the same cycle.
    assign do_push = push & ~full_q;
    assign do_pop  = pop & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == (AW+1)'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/prime_collector.sv
// Collects up to a programmed number of primes per session into a FIFO,
// counting accepted primes and discarded non-primes.
module prime_collector
    import prime_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  limit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_prime,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  dropped,
    output logic              busy,
    output logic              done
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   limit_q, limit_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   dropped_q, dropped_d;
    logic               fifo_full, fifo_empty, fifo_push;
    logic [DATA_W-1:0]  fifo_head;
    logic               xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(DROP_MAX)) ? v : v + 1'b1;
    endfunction

    assign in_ready  = (state_q == COLLECT) & ~fifo_full;
    assign xfer      = in_valid & in_ready;
    assign fifo_push = xfer & in_prime;

    always_comb begin
        state_d   = state_q;
        limit_d   = limit_q;
        count_d   = count_q;
        dropped_d = dropped_q;
        case (state_q)
            IDLE, DONE: begin
                // Restart from DONE leaves the FIFO alone; old entries drain first.
                if (start) begin
                    limit_d   = limit;
                    count_d   = '0;
                    dropped_d = '0;
                    state_d   = (limit == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (xfer) begin
                    if (in_prime) begin
                        count_d = count_q + 1'b1;
                        if (count_d == limit_q) state_d = DONE;
                    end else begin
                        dropped_d = sat_inc(dropped_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            limit_q   <= '0;
            count_q   <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
        end
    end

    prime_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Storage is not reset, so mask the head while nothing is buffered.
    assign out_valid = ~fifo_empty;
    assign out_data  = out_valid ? fifo_head : '0;
    assign count     = count_q;
    assign dropped   = dropped_q;
    assign busy      = (state_q == COLLECT);
    assign done      = (state_q == DONE);
endmodule

// File: tb/tb_prime_collector.sv
// Directed bench for prime_collector: hand-computed vectors for sessions,
// backpressure, drop saturation, simultaneous push/pop and mid-session reset.
module tb_prime_collector;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] limit;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_prime;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] count;
    logic [3:0] dropped;
    logic       busy;
    logic       done;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] popped[$];

    prime_collector dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .limit     (limit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_prime  (in_prime),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .dropped   (dropped),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Inputs only change 1ns after a rising edge, so a handshake seen here
    // is the one the next rising edge will complete.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) popped.push_back(out_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [3:0] lim);
        start = 1'b1;
        limit = lim;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic p, input string tag);
        int  waited;
        bit  acc;
        in_valid = 1'b1;
        in_data  = d;
        in_prime = p;
        acc      = 1'b0;
        waited   = 0;
        while (!acc && waited < 20) begin
            if (in_ready) acc = 1'b1;
            tick(1);
            waited++;
        end
        in_valid = 1'b0;
        if (!acc) check(tag, 0, 1);
    endtask

    task automatic check_popped(input string tag, input int exp_vals[$]);
        check({tag, "_n"}, popped.size(), exp_vals.size());
        for (int i = 0; i < exp_vals.size(); i++)
            check(tag, (i < popped.size()) ? popped[i] : 8'hxx, exp_vals[i]);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        limit     = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_prime  = 1'b0;
        out_ready = 1'b0;
        tick(2);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_count", count, 0);
        check("rst_dropped", dropped, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        tick(1);

        // Session with limit 3, consumer always ready.
        out_ready = 1'b1;
        do_start(4'd3);
        check("s1_busy", busy, 1);
        check("s1_in_ready", in_ready, 1);
        send(8'd4, 1'b0, "s1_acc4");
        send(8'd5, 1'b1, "s1_acc5");
        send(8'd6, 1'b0, "s1_acc6");
        send(8'd7, 1'b1, "s1_acc7");
        send(8'd11, 1'b1, "s1_acc11");
        check("s1_done", done, 1);
        check("s1_in_ready_done", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 8'd13;
        in_prime = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("s1_13_blocked", in_ready, 0);
            tick(1);
        end
        in_valid = 1'b0;
        check("s1_count", count, 3);
        check("s1_dropped", dropped, 2);
        check_popped("s1_pop", '{5, 7, 11});

        // Limit 0 goes straight to DONE.
        popped.delete();
        do_start(4'd0);
        check("s2_done", done, 1);
        check("s2_busy", busy, 0);
        check("s2_count", count, 0);
        check("s2_dropped", dropped, 0);
        in_valid = 1'b1;
        in_prime = 1'b1;
        in_data  = 8'd17;
        for (int i = 0; i < 3; i++) begin
            check("s2_in_ready", in_ready, 0);
            tick(1);
        end
        in_valid = 1'b0;

        // Backpressure: fill all 8 entries, then release the consumer.
        out_ready = 1'b0;
        do_start(4'd10);
        send(8'd2, 1'b1, "s3_acc");
        send(8'd3, 1'b1, "s3_acc");
        send(8'd5, 1'b1, "s3_acc");
        send(8'd7, 1'b1, "s3_acc");
        send(8'd11, 1'b1, "s3_acc");
        send(8'd13, 1'b1, "s3_acc");
        send(8'd17, 1'b1, "s3_acc");
        send(8'd19, 1'b1, "s3_acc");
        check("s3_full_in_ready", in_ready, 0);
        check("s3_head", out_data, 2);
        tick(2);
        check("s3_still_full", in_ready, 0);
        check("s3_no_pop", popped.size(), 0);
        in_valid  = 1'b1;
        in_data   = 8'd23;
        in_prime  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("s3_full_oready", in_ready, 0);
        send(8'd23, 1'b1, "s3_acc23");
        tick(12);
        check("s3_count", count, 9);
        check("s3_busy", busy, 1);
        check_popped("s3_pop", '{2, 3, 5, 7, 11, 13, 17, 19, 23});
        send(8'd29, 1'b1, "s3_acc29");
        check("s3_done", done, 1);
        check("s3_count10", count, 10);
        tick(3);

        // Drop counter saturation.
        popped.delete();
        do_start(4'd1);
        for (int i = 0; i < 20; i++) send(8'(100 + i), 1'b0, "s4_acc");
        check("s4_dropped_sat", dropped, 15);
        check("s4_busy", busy, 1);
        check("s4_count", count, 0);
        check("s4_out_valid", out_valid, 0);
        send(8'd31, 1'b1, "s4_acc31");
        check("s4_done", done, 1);
        check("s4_count1", count, 1);
        check("s4_dropped_hold", dropped, 15);
        tick(3);
        check_popped("s4_pop", '{31});

        // Simultaneous push and pop at occupancy 4.
        popped.delete();
        out_ready = 1'b0;
        do_start(4'd10);
        for (int i = 0; i < 4; i++) send(8'(40 + i), 1'b1, "s5_acc");
        check("s5_head", out_data, 40);
        out_ready = 1'b1;
        send(8'd44, 1'b1, "s5_acc44");
        out_ready = 1'b0;
        check("s5_valid_after", out_valid, 1);
        check("s5_head_after", out_data, 41);
        check("s5_one_pop", popped.size(), 1);
        out_ready = 1'b1;
        tick(8);
        out_ready = 1'b0;
        check_popped("s5_pop", '{40, 41, 42, 43, 44});
        check("s5_empty", out_valid, 0);

        // Asynchronous reset with three entries buffered.
        send(8'd50, 1'b1, "s6_acc");
        send(8'd51, 1'b1, "s6_acc");
        send(8'd52, 1'b1, "s6_acc");
        check("s6_pre_valid", out_valid, 1);
        check("s6_pre_count", count, 8);
        #2;
        rst = 1'b0;
        #1;
        check("s6_rst_out_valid", out_valid, 0);
        check("s6_rst_out_data", out_data, 0);
        check("s6_rst_in_ready", in_ready, 0);
        check("s6_rst_count", count, 0);
        check("s6_rst_dropped", dropped, 0);
        check("s6_rst_busy", busy, 0);
        check("s6_rst_done", done, 0);
        tick(2);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_prime  = 1'b1;
        out_ready = 1'b1;
        tick(3);
        check("s6_post_out_valid", out_valid, 0);
        check("s6_post_busy", busy, 0);
        check("s6_post_done", done, 0);
        check("s6_post_in_ready", in_ready, 0);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
